// File: rtl/afpm_seq_ctrl.sv
// Sequencer between the byte-wide pins and the 16-bit log-approximate FP multiplier core.
// It assembles two-beat operands, starts the core, and streams the result out (or NaN on a timeout).
module afpm_seq_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [15:0] NAN_VAL = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        in_valid,
    input  logic [7:0]  a_byte,
    input  logic [7:0]  b_byte,
    output logic        in_ready,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        core_start,
    input  logic        core_done,
    input  logic [15:0] core_result,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    output logic        out_first,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI,
        S_ISSUE,
        S_WAIT,
        S_OUT_LO,
        S_OUT_HI
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic [15:0] res_q, res_d;
    logic        terr_q, terr_d;
    logic        start_q, start_d;
    logic        oval_q, oval_d;
    logic        ofirst_q, ofirst_d;
    logic [7:0]  obyte_q, obyte_d;
    logic        accept;

    assign in_ready = ena & ((state_q == S_IDLE) | (state_q == S_LOAD_HI));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        terr_d  = terr_q;
        if (ena) begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_a_d[7:0] = a_byte;
                        op_b_d[7:0] = b_byte;
                        terr_d      = 1'b0;
                        state_d     = S_LOAD_HI;
                    end
                end
                S_LOAD_HI: begin
                    if (accept) begin
                        op_a_d[15:8] = a_byte;
                        op_b_d[15:8] = b_byte;
                        state_d      = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the expiry edge takes priority over the watchdog.
                    if (core_done) begin
                        res_d   = core_result;
                        state_d = S_OUT_LO;
                    end else if (cnt_q >= CNT_LAST) begin
                        res_d   = NAN_VAL;
                        terr_d  = 1'b1;
                        state_d = S_OUT_LO;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_OUT_LO: state_d = S_OUT_HI;
                S_OUT_HI: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output flops hold the decode of the state being entered; while ena is low they hold
    // along with the state and are masked at the pins, so the action replays when ena returns.
    always_comb begin
        start_d  = (state_d == S_ISSUE);
        oval_d   = (state_d == S_OUT_LO) | (state_d == S_OUT_HI);
        ofirst_d = (state_d == S_OUT_LO);
        obyte_d  = 8'd0;
        if (state_d == S_OUT_LO) begin
            obyte_d = res_d[7:0];
        end else if (state_d == S_OUT_HI) begin
            obyte_d = res_d[15:8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            op_a_q   <= 16'd0;
            op_b_q   <= 16'd0;
            res_q    <= 16'd0;
            terr_q   <= 1'b0;
            start_q  <= 1'b0;
            oval_q   <= 1'b0;
            ofirst_q <= 1'b0;
            obyte_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            terr_q   <= terr_d;
            start_q  <= start_d;
            oval_q   <= oval_d;
            ofirst_q <= ofirst_d;
            obyte_q  <= obyte_d;
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign timeout_err = terr_q;
    assign core_start  = start_q & ena;
    assign out_valid   = oval_q & ena;
    assign out_first   = ofirst_q & ena;
    assign out_byte    = obyte_q & {8{ena}};

endmodule

// File: tb/tb_afpm_seq_ctrl.sv
// Directed bench for afpm_seq_ctrl: a behavioural core plus a byte scoreboard checked every cycle.
module tb_afpm_seq_ctrl;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n, ena, in_valid, core_done;
    logic [7:0]  a_byte, b_byte, out_byte;
    logic [15:0] op_a, op_b, core_result;
    logic        in_ready, core_start, out_valid, out_first, timeout_err;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    int starts = 0;
    int start_cyc = -1;
    int lo_cyc = -1;
    int done_dly = 1;
    int starts_b;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    afpm_seq_ctrl #(.TIMEOUT(TMO), .NAN_VAL(16'h7E00)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
        .a_byte(a_byte), .b_byte(b_byte), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .core_start(core_start),
        .core_done(core_done), .core_result(core_result),
        .out_byte(out_byte), .out_valid(out_valid), .out_first(out_first),
        .timeout_err(timeout_err)
    );

    // Behavioural log-domain multiplier: add the fp16 bit patterns and remove one bias.
    function automatic logic [15:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        return a + b - 16'h3C00;
    endfunction

    assign core_result = mul_ref(op_a, op_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_res(input logic [15:0] r);
        exp_q.push_back({1'b1, r[7:0]});
        exp_q.push_back({1'b0, r[15:8]});
    endtask

    // One clock: monitor at the falling edge, then drive the core model just after the rising edge.
    task automatic cyc();
        logic [8:0] e;
        @(negedge clk);
        ncyc++;
        if (core_start) begin
            starts++;
            start_cyc = ncyc;
        end
        if (out_valid) begin
            if (out_first) lo_cyc = ncyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_byte", 32'(out_byte), 32'(e[7:0]));
                chk("out_first", 32'(out_first), 32'(e[8]));
            end
        end else begin
            chk("idle_out", 32'({out_first, out_byte}), 32'd0);
        end
        @(posedge clk);
        #1;
        core_done = (done_dly > 0) && (start_cyc >= 0) && (ncyc == start_cyc + done_dly - 1);
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        a_byte   = a;
        b_byte   = b;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0;
        a_byte = 8'd0; b_byte = 8'd0; core_done = 1'b0;
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_op_b", 32'(op_b), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Nominal frame
        starts_b = starts;
        beat(8'h00, 8'h00);
        beat(8'h3E, 8'h42);
        push_res(16'h4400);
        chk("nom_op_a", 32'(op_a), 32'h3E00);
        chk("nom_op_b", 32'(op_b), 32'h4200);
        wait_out("nom", 20);
        chk("nom_starts", 32'(starts - starts_b), 32'd1);
        chk("nom_latency", 32'(lo_cyc - start_cyc), 32'd2);
        chk("nom_terr", 32'(timeout_err), 32'd0);
        chk("nom_ready", 32'(in_ready), 32'd1);

        // Gapped load
        starts_b = starts;
        beat(8'h00, 8'h00);
        for (int i = 0; i < 3; i++) cyc();
        chk("gap_ready", 32'(in_ready), 32'd1);
        chk("gap_nostart", 32'(starts - starts_b), 32'd0);
        beat(8'h3E, 8'h42);
        push_res(16'h4400);
        wait_out("gap", 20);
        chk("gap_starts", 32'(starts - starts_b), 32'd1);

        // Timeout with core_done tied low
        done_dly = 0;
        beat(8'h11, 8'h33);
        beat(8'h22, 8'h44);
        push_res(16'h7E00);
        wait_out("tmo", 40);
        chk("tmo_latency", 32'(lo_cyc - start_cyc), 32'(TMO + 1));
        chk("tmo_terr", 32'(timeout_err), 32'd1);
        chk("tmo_op_a", 32'(op_a), 32'h2211);

        // Next beat 0 clears the flag; done lands exactly on the expiry edge
        done_dly = TMO;
        beat(8'h34, 8'h80);
        chk("tmo_clear", 32'(timeout_err), 32'd0);
        beat(8'h3D, 8'h41);
        push_res(mul_ref(16'h3D34, 16'h4180));
        wait_out("race", 40);
        chk("race_latency", 32'(lo_cyc - start_cyc), 32'(TMO + 1));
        chk("race_terr", 32'(timeout_err), 32'd0);

        // in_valid held high with a new byte every cycle
        done_dly = 1;
        starts_b = starts;
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            a_byte   = 8'(16 + 7 * i);
            b_byte   = 8'(200 - 3 * i);
            if (i % 6 == 1) begin
                push_res(mul_ref({8'(16 + 7 * i), 8'(16 + 7 * (i - 1))},
                                 {8'(200 - 3 * i), 8'(200 - 3 * (i - 1))}));
            end
            cyc();
            if (i % 6 == 1) begin
                chk("stream_op_a", 32'(op_a), 32'({8'(16 + 7 * i), 8'(16 + 7 * (i - 1))}));
                chk("stream_op_b", 32'(op_b), 32'({8'(200 - 3 * i), 8'(200 - 3 * (i - 1))}));
            end
        end
        in_valid = 1'b0;
        wait_out("stream", 20);
        chk("stream_starts", 32'(starts - starts_b), 32'd3);

        // ena low for two cycles in OUT_LO
        beat(8'h00, 8'h00);
        beat(8'h40, 8'h3C);
        push_res(mul_ref(16'h4000, 16'h3C00));
        cyc();
        cyc();
        ena = 1'b0;
        cyc();
        chk("ena_lo_ready", 32'(in_ready), 32'd0);
        cyc();
        ena = 1'b1;
        wait_out("ena_out", 20);

        // ena low for two cycles in ISSUE
        starts_b = starts;
        beat(8'h00, 8'h00);
        beat(8'h44, 8'h3E);
        push_res(mul_ref(16'h4400, 16'h3E00));
        ena = 1'b0;
        cyc();
        cyc();
        chk("ena_iss_nostart", 32'(starts - starts_b), 32'd0);
        ena = 1'b1;
        wait_out("ena_iss", 20);
        chk("ena_iss_starts", 32'(starts - starts_b), 32'd1);
        chk("ena_iss_latency", 32'(lo_cyc - start_cyc), 32'd2);

        // Reset in the middle of WAIT; the late done must be ignored
        done_dly = 6;
        beat(8'h12, 8'h34);
        beat(8'h56, 8'h78);
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_op_a", 32'(op_a), 32'd0);
        chk("mid_rst_op_b", 32'(op_b), 32'd0);
        chk("mid_rst_start", 32'(core_start), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_byte", 32'(out_byte), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        cyc();
        cyc();
        rst_n = 1'b1;
        starts_b = starts;
        for (int i = 0; i < 8; i++) cyc();
        chk("post_rst_nostart", 32'(starts - starts_b), 32'd0);
        chk("post_rst_terr", 32'(timeout_err), 32'd0);

        done_dly = 1;
        beat(8'h00, 8'h00);
        beat(8'h3E, 8'h42);
        push_res(16'h4400);
        wait_out("post_rst", 20);
        chk("post_rst_starts", 32'(starts - starts_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/afpm_seq_ctrl.md
# afpm_seq_ctrl

Sequencing controller for the 16-bit logarithmic approximate floating-point multiplier core. It sits between the byte-wide operand/result pins and the multiplier datapath. It assembles two byte-serial beats per operand (low byte first) into 16-bit operands A and B and issues a one-cycle start to the core. It then waits for completion, with a timeout watchdog, and streams the 16-bit result back out as two bytes, low byte first.

## Interface
Parameters:
- TIMEOUT, 15: maximum number of WAIT cycles before the result is forced to NaN; legal range 1–255.
- NAN_VAL, 16'h7E00: result substituted on timeout.

Ports:
- clk  in  1  design clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  design enable; low freezes the controller
- in_valid  in  1  operand beat present on a_byte/b_byte
- a_byte  in  8  operand A byte (beat 0 = A[7:0], beat 1 = A[15:8])
- b_byte  in  8  operand B byte (same ordering)
- in_ready  out  1  controller accepts a beat this cycle
- op_a  out  16  registered operand A to the core
- op_b  out  16  registered operand B to the core
- core_start  out  1  one-cycle start pulse to the core
- core_done  in  1  core result valid (level, sampled only in WAIT)
- core_result  in  16  core product
- out_byte  out  8  result byte; 0 when out_valid is low
- out_valid  out  1  out_byte carries a result byte
- out_first  out  1  high with the low result byte
- timeout_err  out  1  sticky; last operation timed out

## Operation
- States: IDLE, LOAD_HI, ISSUE, WAIT, OUT_LO, OUT_HI. A beat is accepted when in_valid & in_ready & ena.
- in_ready = ena & (state==IDLE | state==LOAD_HI).
- IDLE, beat accepted: op_a[7:0]←a_byte, op_b[7:0]←b_byte, timeout_err←0, next LOAD_HI.
- LOAD_HI: beat accepted: op_a[15:8]←a_byte, op_b[15:8]←b_byte, next ISSUE. No beat: stay, with no timeout.
- ISSUE: core_start=1 for exactly this cycle; wait counter←0; next WAIT.
- WAIT: each cycle, core_done sampled:
  - core_done=1: result register←core_result; next OUT_LO.
  - Otherwise counter increments.
  - counter==TIMEOUT-1 and core_done=0: result←NAN_VAL, timeout_err←1, next OUT_LO.
  - core_done and expiry on the same edge: core_done wins, and timeout_err is not set.
- core_done outside WAIT is ignored.
- OUT_LO: out_valid=1, out_first=1, out_byte=result[7:0]; next OUT_HI.
- OUT_HI: out_valid=1, out_first=0, out_byte=result[15:8]; next IDLE.
- Beats presented in ISSUE, WAIT, OUT_LO or OUT_HI are dropped (in_ready=0), not queued.
- ena=0: state, counter and all registers hold; core_start, out_valid and out_first are forced to 0. The pending action re-occurs in full when ena returns: the start pulse is reissued, or the byte is re-presented.
- Reset asserted in any state: immediate return to IDLE and the operation is abandoned; no core_start is emitted after reset release until a new two-beat frame arrives.

## Timing
- Reset values: state IDLE; op_a=op_b=0; result=0; counter=0; core_start=0; out_byte=0; out_valid=0; out_first=0; timeout_err=0; in_ready=ena.
- Beat 0 is accepted at edge k and beat 1 at edge k+1 (back-to-back minimum); core_start is high during cycle k+1..k+2.
- op_a and op_b are stable from edge k+1 until the next accepted beat 0.
- core_done sampled high at edge m (m ≥ k+3): low byte is valid during cycle m..m+1, high byte during m+1..m+2, and in_ready rises after edge m+2.
- Minimum frame-to-frame period with a 1-cycle core is 6 cycles.
- Timeout: if core_done never rises, OUT_LO is entered TIMEOUT cycles after WAIT entry.
- All outputs are registered except in_ready (combinational from state and ena).

## Test plan
- Nominal frame: beats (0x00,0x00) then (0x3E,0x42); the model core asserts done one cycle after start with result 16'h4400 → op_a=16'h3E00, op_b=16'h4200, one core_start pulse; out_byte 0x00 with out_first=1, then 0x44; timeout_err=0.
- Gapped load: beat 0, then in_valid low for 3 cycles, then beat 1 → FSM holds LOAD_HI, the core_start pulse is single, and the result is the same as nominal.
- Timeout with TIMEOUT=15 and core_done tied low → exactly 15 WAIT cycles, then out_byte 0x00 then 0x7E and timeout_err=1. timeout_err clears on the next accepted beat 0. A separate run with core_done rising on the expiry edge outputs core_result with timeout_err=0.
- in_valid held high continuously with changing bytes → only beats in IDLE/LOAD_HI are captured, and a new frame starts only after OUT_HI.
- ena dropped for 2 cycles during OUT_LO → out_valid=0 for those cycles, then the low byte is re-presented and followed by the high byte, with no byte lost or duplicated. ena dropped during ISSUE → core_start deferred, still a single pulse.
- rst_n pulsed low mid-WAIT → all outputs return to reset values immediately; a late core_done produces no output; the next full frame completes normally.
